if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage: PC register, next-PC selection, instruction-memory request handshake, and IF/ID pipeline register.
- Consumes pc_write, if_id_write and if_id_flush from the hazard unit, plus redirect information from EX.
- Produces the if_id_instruction and PC+4 that ID and the hazard unit consume.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on flush or bubble.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pc_write  in  1  hazard unit: PC may update.
- if_id_write  in  1  hazard unit: IF/ID may load.
- if_id_flush  in  1  hazard unit: squash IF/ID.
- ex_pc_src_sel  in  3  EX-stage PCSRC code.
- ex_branch_taken  in  1  EX ALU result bit 0.
- ex_branch_target  in  32  branch target.
- ex_jump_target  in  32  J/JAL target.
- ex_jr_target  in  32  JR register value.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (word aligned).
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- pc  out  32  current fetch PC.
- if_id_instruction  out  32  IF/ID instruction.
- if_id_pc_plus4  out  32  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset values:
  - pc=RESET_PC, imem_req=0, if_id_instruction=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0.
  - Hold buffer empty; FSM=FETCH.
  - imem_req rises the cycle after rst deasserts.
- Redirect:
  - redirect = (sel==PCSRC_JR) | (sel==PCSRC_JT) | (sel==PCSRC_BT & ex_branch_taken).
  - Target mux: JR→ex_jr_target, JT→ex_jump_target, BT→ex_branch_target.
- Address and request:
  - imem_addr=pc always.
  - imem_req=1 in FETCH and DROP while the hold buffer is empty.
  - imem_addr must not change while a request is outstanding (req=1, no ack).
- FSM states FETCH, DROP:
  - FETCH, ack, no redirect:
    - If if_id_write=1, load IF/ID with {imem_rdata, pc+4, valid=1}; if also pc_write=1, pc<=pc+4.
    - If if_id_write=0, capture data in the 1-entry hold buffer; imem_req drops; pc unchanged.
  - FETCH, redirect with ack, or with no request outstanding: pc<=target, data discarded, stay in FETCH.
  - FETCH, redirect while a request is outstanding without ack: latch target into redirect_pc, go to DROP.
  - DROP: imem_req stays 1 on the old address. On ack, discard data, pc<=redirect_pc, go to FETCH. A further redirect in DROP overwrites redirect_pc.
- Hold buffer:
  - When if_id_write returns to 1 with no flush, the buffer moves to IF/ID and pc<=pc+4 if pc_write=1.
  - Redirect or flush empties the buffer.
- IF/ID register:
  - if_id_flush has priority over write: loads NOP_INSTR, valid=0.
  - if_id_write=1 with no instruction available (no ack, buffer empty): loads a bubble, NOP_INSTR with valid=0.
  - if_id_write=0 and no flush: IF/ID holds.
- Simultaneous events: priority is rst > redirect/flush > stall > normal fetch.
- Reset mid-request: state returns to reset values; an ack arriving in the reset cycle is ignored.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. pc[1:0] is forced to 0 on every load.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds outputs perf_fetch_cnt[31:0], perf_stall_cnt[31:0] and perf_flush_cnt[31:0], all reset to 0, wrapping.
  - perf_fetch_cnt increments when a valid instruction loads into IF/ID.
  - perf_stall_cnt increments per cycle with if_id_write=0 and no flush.
  - perf_flush_cnt increments per cycle with if_id_flush=1.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines:
  - PCSRC_* codes, PC_WRITE_*, IF_ID_WRITE_*, IF_ID_FLUSH_* values.
  - NOP encoding, IF FSM state encoding.
- One sub-module, if_id_reg: the IF/ID register with write/flush/bubble priority. The fetch FSM and PC stay in if_stage.

Test Plan:
- Reset, then ack every cycle with rdata=addr^32'hA5A5_0000 → pc steps 0x3000, 0x3004, 0x3008; IF/ID shows matching words, valid=1; pc_plus4 = addr+4.
- Load-use stall (pc_write=0, if_id_write=0 for 1 cycle) with ack in that cycle → buffer captures, imem_req=0; next cycle word enters IF/ID and pc advances by exactly 4, nothing lost or duplicated.
- ex_pc_src_sel=BT, taken=1, target=0x3100, ack same cycle → IF/ID=NOP with valid=0; next imem_addr=0x3100. With taken=0: no redirect, sequential fetch.
- JR to 0x3200 while a request to 0x3008 has no ack for 3 cycles → imem_addr stays 0x3008 through the wait; ack data dropped; next address 0x3200; no valid IF/ID entry from 0x3008.
- rst asserted during an outstanding request with ack in the same cycle → pc=0x3000, IF/ID=NOP, valid=0.
- PC at 0xFFFF_FFFC, ack → pc wraps to 0x0000_0000. With IF_PERF_CNT_EN, 2 stall cycles + 1 flush → perf_stall_cnt=2, perf_flush_cnt=1.

Source files
------------

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_pkg
//  Description : Shared encodings for the instruction-fetch stage: PC source
//                codes, hazard-unit control values, NOP word, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // EX-stage PC source select codes
    localparam logic [2:0] PCSRC_PC4 = 3'd0;
    localparam logic [2:0] PCSRC_BT  = 3'd1;
    localparam logic [2:0] PCSRC_JT  = 3'd2;
    localparam logic [2:0] PCSRC_JR  = 3'd3;

    // Hazard-unit control values
    localparam logic PC_WRITE_EN      = 1'b1;
    localparam logic PC_WRITE_HOLD    = 1'b0;
    localparam logic IF_ID_WRITE_EN   = 1'b1;
    localparam logic IF_ID_WRITE_HOLD = 1'b0;
    localparam logic IF_ID_FLUSH_EN   = 1'b1;
    localparam logic IF_ID_FLUSH_NONE = 1'b0;

    // Instruction word used for bubbles and squashed slots
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } if_state_e;

    // True when the EX stage requests a change of control flow
    function automatic logic is_redirect(input logic [2:0] sel, input logic taken);
        return (sel == PCSRC_JR) || (sel == PCSRC_JT) || ((sel == PCSRC_BT) && taken);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Instruction-memory request/acknowledge bus. The fetch stage
//                is the master; the memory is the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Priority is reset, flush, then
//                write; a write with no instruction available inserts a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_write,
    input  wire logic        i_flush,
    input  wire logic        i_instr_avail,
    input  wire logic [31:0] i_instr,
    input  wire logic [31:0] i_pc_plus4,
    output logic [31:0]      o_instruction,
    output logic [31:0]      o_pc_plus4,
    output logic             o_valid
);

    // Load, squash, bubble or hold the pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            o_instruction <= NOP_INSTR;
            o_pc_plus4    <= 32'd0;
            o_valid       <= 1'b0;
        end else if (i_flush) begin
            o_instruction <= NOP_INSTR;
            o_pc_plus4    <= 32'd0;
            o_valid       <= 1'b0;
        end else if (i_write) begin
            if (i_instr_avail) begin
                o_instruction <= i_instr;
                o_pc_plus4    <= i_pc_plus4;
                o_valid       <= 1'b1;
            end else begin
                o_instruction <= NOP_INSTR;
                o_pc_plus4    <= 32'd0;
                o_valid       <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage: PC register, next-PC selection,
//                instruction-memory handshake with one-entry hold buffer,
//                and IF/ID register.
//  Options     : IF_PERF_CNT_EN - adds fetch/stall/flush performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        pc_write,
    input  wire logic        if_id_write,
    input  wire logic        if_id_flush,
    input  wire logic [2:0]  ex_pc_src_sel,
    input  wire logic        ex_branch_taken,
    input  wire logic [31:0] ex_branch_target,
    input  wire logic [31:0] ex_jump_target,
    input  wire logic [31:0] ex_jr_target,
    if_stage_if.master       imem,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instruction,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    if_state_e   r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_redirect_pc, w_redirect_pc_nxt;
    logic        r_hold_valid, w_hold_valid_nxt;
    logic [31:0] r_hold_data, w_hold_data_nxt;
    logic        r_req_en;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_req;
    logic        w_ack;
    logic [31:0] w_pc_plus4;
    logic        w_pc_we;
    logic        w_if_id_we;
    logic        w_if_id_flush;
    logic        w_instr_avail;
    logic [31:0] w_instr;

    assign w_pc_we       = (pc_write == PC_WRITE_EN);
    assign w_if_id_we    = (if_id_write == IF_ID_WRITE_EN);
    assign w_if_id_flush = (if_id_flush == IF_ID_FLUSH_EN);

    // Redirect decode and target selection
    always_comb begin
        w_redirect = is_redirect(ex_pc_src_sel, ex_branch_taken);
        case (ex_pc_src_sel)
            PCSRC_JR: w_target = ex_jr_target;
            PCSRC_JT: w_target = ex_jump_target;
            default:  w_target = ex_branch_target;
        endcase
    end

    // Request is held off for the first cycle out of reset and while the hold buffer is full
    assign w_req      = r_req_en & ~r_hold_valid;
    assign w_ack      = w_req & imem.imem_ack;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign pc             = r_pc;

    // Fetch FSM: next state, next PC, hold buffer and IF/ID source
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_redirect_pc_nxt = r_redirect_pc;
        w_hold_valid_nxt  = r_hold_valid;
        w_hold_data_nxt   = r_hold_data;
        w_instr_avail     = 1'b0;
        w_instr           = r_hold_data;
        case (r_state)
            FETCH: begin
                if (w_redirect) begin
                    // Redirect squashes any buffered or returning word
                    w_hold_valid_nxt = 1'b0;
                    if (w_req && !w_ack) begin
                        // Address must stay stable until the memory answers
                        w_redirect_pc_nxt = w_target;
                        w_state_nxt       = DROP;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end else if (r_hold_valid) begin
                    if (w_if_id_flush) begin
                        w_hold_valid_nxt = 1'b0;
                        if (w_pc_we) w_pc_nxt = w_pc_plus4;
                    end else if (w_if_id_we) begin
                        w_instr_avail    = 1'b1;
                        w_hold_valid_nxt = 1'b0;
                        if (w_pc_we) w_pc_nxt = w_pc_plus4;
                    end
                end else if (w_ack) begin
                    if (w_if_id_flush) begin
                        if (w_pc_we) w_pc_nxt = w_pc_plus4;
                    end else if (w_if_id_we) begin
                        w_instr_avail = 1'b1;
                        w_instr       = imem.imem_rdata;
                        if (w_pc_we) w_pc_nxt = w_pc_plus4;
                    end else begin
                        // Stalled: park the word so it is not lost
                        w_hold_valid_nxt = 1'b1;
                        w_hold_data_nxt  = imem.imem_rdata;
                    end
                end
            end
            DROP: begin
                if (w_redirect) w_redirect_pc_nxt = w_target;
                if (w_ack) begin
                    w_pc_nxt    = w_redirect ? w_target : r_redirect_pc;
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    // State and fetch-path registers; PC is always kept word aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_pc          <= {RESET_PC[31:2], 2'b00};
            r_redirect_pc <= 32'd0;
            r_hold_valid  <= 1'b0;
            r_hold_data   <= NOP_INSTR;
            r_req_en      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= {w_pc_nxt[31:2], 2'b00};
            r_redirect_pc <= w_redirect_pc_nxt;
            r_hold_valid  <= w_hold_valid_nxt;
            r_hold_data   <= w_hold_data_nxt;
            r_req_en      <= 1'b1;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk           (clk),
        .rst           (rst),
        .i_write       (w_if_id_we),
        .i_flush       (w_if_id_flush),
        .i_instr_avail (w_instr_avail),
        .i_instr       (w_instr),
        .i_pc_plus4    (w_pc_plus4),
        .o_instruction (if_id_instruction),
        .o_pc_plus4    (if_id_pc_plus4),
        .o_valid       (if_id_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt, r_stall_cnt, r_flush_cnt;
    logic        w_if_id_load;

    assign w_if_id_load = w_instr_avail & w_if_id_we & ~w_if_id_flush;

    // Free-running wrapping event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_if_id_load)                  r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (!w_if_id_we && !w_if_id_flush) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_if_id_flush)                 r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
